// File: rtl/i2c_slave_receiver.sv
`timescale 1ns/1ps
// I2C write-only target: conditions SCL/SDA, decodes [addr+W, sub, data] frames,
// ACKs by pulling SDA low and strobes each completed {sub, data} pair.
module i2c_slave_receiver #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h1A,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] SUB_ADDR,
  output logic [7:0] WR_DATA,
  output logic       WR_VALID,
  output logic       BUSY,
  output logic       ERR
);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned SCL_I = 0;
  localparam int unsigned SDA_I = 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, IGNORE
  } state_e;

  logic                   sda_in;
  logic [1:0]             s1_q, s1_d, s2_q, s2_d;
  logic [1:0]             filt_q, filt_d, prev_q, prev_d;
  logic [1:0][CNT_W-1:0]  fcnt_q, fcnt_d;

  state_e                 state_q, state_d;
  logic [BIT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             sub_lat_q, sub_lat_d;
  logic [7:0]             sub_addr_q, sub_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic scl_rise_c, scl_fall_c, scl_high_c, start_c, stop_c, aborting_c;

  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in   = I2C_SDAT;

  // Two-stage synchronizer followed by a per-line stability filter
  always_comb begin
    s1_d   = {sda_in, I2C_SCLK};
    s2_d   = s1_q;
    prev_d = filt_q;
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == CNT_W'(FILTER_LEN - 1)) filt_d[i] = s2_q[i];
        else                                      fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign scl_high_c = filt_q[SCL_I] & prev_q[SCL_I];
  assign scl_rise_c = filt_q[SCL_I] & ~prev_q[SCL_I];
  assign scl_fall_c = ~filt_q[SCL_I] & prev_q[SCL_I];
  assign start_c    = scl_high_c & prev_q[SDA_I] & ~filt_q[SDA_I];
  assign stop_c     = scl_high_c & ~prev_q[SDA_I] & filt_q[SDA_I];
  assign aborting_c = (state_q == SUB) || (state_q == SUB_ACK) || (state_q == DATA);

  // Frame decoder; START/STOP override everything else
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    sub_lat_d  = sub_lat_q;
    sub_addr_d = sub_addr_q;
    wr_data_d  = wr_data_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    err_d      = 1'b0;
    if (start_c) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      busy_d   = 1'b1;
      sda_oe_d = 1'b0;
      err_d    = aborting_c;
    end else if (stop_c) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      err_d    = aborting_c;
    end else begin
      case (state_q)
        ADDR, SUB, DATA: begin
          if (scl_rise_c && bitcnt_q != BIT_W'(8)) begin
            shift_d  = {shift_q[6:0], filt_q[SDA_I]};
            bitcnt_d = bitcnt_q + BIT_W'(1);
          end else if (scl_fall_c && bitcnt_q == BIT_W'(8)) begin
            bitcnt_d = '0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
                sda_oe_d = 1'b1;
                state_d  = ADDR_ACK;
              end else begin
                state_d  = IGNORE;
              end
            end else if (state_q == SUB) begin
              sda_oe_d  = 1'b1;
              sub_lat_d = shift_q;
              state_d   = SUB_ACK;
            end else begin
              sda_oe_d   = 1'b1;
              sub_addr_d = sub_lat_q;
              wr_data_d  = shift_q;
              wr_valid_d = 1'b1;
              state_d    = DATA_ACK;
            end
          end
        end
        ADDR_ACK: if (scl_fall_c) begin sda_oe_d = 1'b0; state_d = SUB;    end
        SUB_ACK:  if (scl_fall_c) begin sda_oe_d = 1'b0; state_d = DATA;   end
        DATA_ACK: if (scl_fall_c) begin sda_oe_d = 1'b0; state_d = IGNORE; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q       <= 2'b11;
      s2_q       <= 2'b11;
      filt_q     <= 2'b11;
      prev_q     <= 2'b11;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      sub_lat_q  <= '0;
      sub_addr_q <= '0;
      wr_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      sub_lat_q  <= sub_lat_d;
      sub_addr_q <= sub_addr_d;
      wr_data_q  <= wr_data_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign SUB_ADDR = sub_addr_q;
  assign WR_DATA  = wr_data_q;
  assign WR_VALID = wr_valid_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule
